// File: rtl/gpu_warp_barrier_if.sv
// Command / release bus of the warp convergence barrier unit.
//   cmd_*  : BSSY/BSYNC/BBREAK/CLEAR commands from warp decode (valid/ready)
//   rel_*  : release records to the warp scheduler (valid/ready)
// master = decode + scheduler side, slave = barrier unit.
interface gpu_warp_barrier_if #(
   parameter int THREADS      = 32,
   parameter int NUM_BARRIERS = 4,
   parameter int PC_W         = 16
);
   localparam int BW = $clog2(NUM_BARRIERS);

   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [BW-1:0]      cmd_bar;
   logic [THREADS-1:0] cmd_mask;
   logic [PC_W-1:0]    cmd_pc;

   logic               rel_valid;
   logic               rel_ready;
   logic [BW-1:0]      rel_bar;
   logic [THREADS-1:0] rel_mask;
   logic [PC_W-1:0]    rel_pc;

   modport master (
      output cmd_valid, cmd_op, cmd_bar, cmd_mask, cmd_pc, rel_ready,
      input  cmd_ready, rel_valid, rel_bar, rel_mask, rel_pc
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_bar, cmd_mask, cmd_pc, rel_ready,
      output cmd_ready, rel_valid, rel_bar, rel_mask, rel_pc
   );
endinterface

// File: rtl/gpu_warp_barrier.sv
// Per-warp convergence barrier unit: NUM_BARRIERS barriers, each with a
// participation mask, an arrival mask and a reconvergence PC. Emits one
// release record (barrier, mask, PC) when all participants have arrived.
//   clk, rst    : clock, asynchronous active-high reset
//   bus (slave) : command and release handshakes
//   active_mask : threads not waiting at any ARMED/RELEASING barrier
//   err         : one-cycle pulse after an illegal command
module gpu_warp_barrier #(
   parameter int THREADS      = 32,
   parameter int NUM_BARRIERS = 4,
   parameter int PC_W         = 16
) (
   input  logic               clk,
   input  logic               rst,
   gpu_warp_barrier_if.slave  bus,
   output logic [THREADS-1:0] active_mask,
   output logic               err
);
   localparam int BW = $clog2(NUM_BARRIERS);

   typedef enum logic [1:0] {IDLE, ARMED, RELEASING} bar_state_e;
   typedef enum logic [1:0] {OP_BSSY, OP_BSYNC, OP_BBREAK, OP_CLEAR} op_e;

   bar_state_e         st_q   [NUM_BARRIERS];
   bar_state_e         st_d   [NUM_BARRIERS];
   logic [THREADS-1:0] part_q [NUM_BARRIERS];
   logic [THREADS-1:0] part_d [NUM_BARRIERS];
   logic [THREADS-1:0] arr_q  [NUM_BARRIERS];
   logic [THREADS-1:0] arr_d  [NUM_BARRIERS];
   logic [PC_W-1:0]    pc_q   [NUM_BARRIERS];
   logic [PC_W-1:0]    pc_d   [NUM_BARRIERS];

   logic               rel_valid_q, rel_valid_d;
   logic [BW-1:0]      rel_bar_q, rel_bar_d;
   logic [THREADS-1:0] rel_mask_q, rel_mask_d;
   logic [PC_W-1:0]    rel_pc_q, rel_pc_d;
   logic               err_q, err_d;

   logic               hs, acc, complete;
   logic [BW-1:0]      b;
   logic [THREADS-1:0] part_new, arr_new, waiting;

   assign hs  = rel_valid_q & bus.rel_ready;
   assign acc = bus.cmd_valid & bus.cmd_ready;
   assign b   = bus.cmd_bar;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q        <= '{default: IDLE};
         part_q      <= '{default: '0};
         arr_q       <= '{default: '0};
         pc_q        <= '{default: '0};
         rel_valid_q <= 1'b0;
         rel_bar_q   <= '0;
         rel_mask_q  <= '0;
         rel_pc_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         st_q        <= st_d;
         part_q      <= part_d;
         arr_q       <= arr_d;
         pc_q        <= pc_d;
         rel_valid_q <= rel_valid_d;
         rel_bar_q   <= rel_bar_d;
         rel_mask_q  <= rel_mask_d;
         rel_pc_q    <= rel_pc_d;
         err_q       <= err_d;
      end
   end

   // Next state: the release handshake is applied first, then the command
   // operates on the post-handshake view, so a BSSY may re-arm the barrier
   // released in the same cycle and a completing command reloads the
   // output register without a bubble.
   always_comb begin
      st_d        = st_q;
      part_d      = part_q;
      arr_d       = arr_q;
      pc_d        = pc_q;
      rel_valid_d = rel_valid_q;
      rel_bar_d   = rel_bar_q;
      rel_mask_d  = rel_mask_q;
      rel_pc_d    = rel_pc_q;
      err_d       = 1'b0;
      complete    = 1'b0;
      part_new    = '0;
      arr_new     = '0;

      if (hs) begin
         st_d[rel_bar_q]   = IDLE;
         part_d[rel_bar_q] = '0;
         arr_d[rel_bar_q]  = '0;
         rel_valid_d       = 1'b0;
      end

      if (acc) begin
         case (op_e'(bus.cmd_op))
            OP_BSSY: begin
               if (st_d[b] == IDLE && |bus.cmd_mask) begin
                  st_d[b]   = ARMED;
                  part_d[b] = bus.cmd_mask;
                  arr_d[b]  = '0;
                  pc_d[b]   = bus.cmd_pc;
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_BSYNC: begin
               if (st_d[b] == ARMED) begin
                  // An ARMED barrier always has a nonzero participation mask.
                  arr_new  = arr_d[b] | (bus.cmd_mask & part_d[b]);
                  arr_d[b] = arr_new;
                  err_d    = |(bus.cmd_mask & ~part_d[b]);
                  complete = (arr_new == part_d[b]);
               end else begin
                  err_d = 1'b1;
               end
            end
            OP_BBREAK: begin
               if (st_d[b] == ARMED) begin
                  part_new  = part_d[b] & ~bus.cmd_mask;
                  arr_new   = arr_d[b] & ~bus.cmd_mask;
                  part_d[b] = part_new;
                  arr_d[b]  = arr_new;
                  if (part_new == '0) st_d[b] = IDLE;
                  else                complete = (arr_new == part_new);
               end else begin
                  err_d = 1'b1;
               end
            end
            default: begin
               st_d[b]   = IDLE;
               part_d[b] = '0;
               arr_d[b]  = '0;
            end
         endcase

         if (complete) begin
            st_d[b]     = RELEASING;
            rel_valid_d = 1'b1;
            rel_bar_d   = b;
            rel_mask_d  = part_d[b];
            rel_pc_d    = pc_d[b];
         end
      end
   end

   // Outputs
   always_comb begin
      waiting = '0;
      for (int unsigned i = 0; i < NUM_BARRIERS; i++) begin
         if (st_q[i] != IDLE) waiting = waiting | arr_q[i];
      end
      active_mask   = ~waiting;
      bus.cmd_ready = ~rel_valid_q | bus.rel_ready;
      bus.rel_valid = rel_valid_q;
      bus.rel_bar   = rel_bar_q;
      bus.rel_mask  = rel_mask_q;
      bus.rel_pc    = rel_pc_q;
      err           = err_q;
   end
endmodule

// File: doc/gpu_warp_barrier.md
# gpu_warp_barrier

Per-warp convergence barrier unit for the SIMT core. It holds `NUM_BARRIERS` hardware barriers, each with a participation mask, an arrival (state) field and a reconvergence PC. Barriers are programmed by BSSY/BSYNC/BBREAK/CLEAR commands from warp decode. When every participant has arrived, the unit emits one release record (mask and PC) to the warp scheduler, which is the next-generation replacement for the single hardcoded barrier in the warp.

## Interface
- `THREADS`, 32, threads per warp (mask width)
- `NUM_BARRIERS`, 4, hardware barriers per warp (≥2, power of two)
- `PC_W`, 16, program counter width
- `BW` (derived), clog2(NUM_BARRIERS), barrier index width

- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_op`  in  2  00 BSSY, 01 BSYNC, 10 BBREAK, 11 CLEAR
- `cmd_bar`  in  BW  target barrier
- `cmd_mask`  in  THREADS  thread mask
- `cmd_pc`  in  PC_W  reconvergence PC (BSSY only)
- `rel_valid`  out  1  release record valid
- `rel_ready`  in  1  scheduler takes record when `rel_valid & rel_ready`
- `rel_bar`  out  BW  released barrier
- `rel_mask`  out  THREADS  threads to resume
- `rel_pc`  out  PC_W  resume PC
- `active_mask`  out  THREADS  threads not waiting at any barrier
- `err`  out  1  one-cycle pulse on an illegal command

## Operation
- Per barrier: state IDLE / ARMED / RELEASING, `part[THREADS]`, `arr[THREADS]`, `pc[PC_W]`.
- BSSY on IDLE with nonzero mask: `part=mask`, `arr=0`, `pc=cmd_pc`, go to ARMED. On non-IDLE barrier or zero mask: err, no change.
- BSYNC on ARMED: `arr |= mask & part`. Mask bits outside `part` raise err; the legal bits still apply. BSYNC on IDLE/RELEASING: err, no change.
- BBREAK on ARMED: `part &= ~mask`, `arr &= ~mask`. If `part` becomes 0, go to IDLE with no release. BBREAK on IDLE: err, no change.
- CLEAR: barrier goes to IDLE, `part=arr=0`, no release, no err, from any state.
- Completion: after BSYNC or BBREAK, if `part != 0` and `arr == part`, the barrier goes to RELEASING and loads the output register with `rel_bar`, `rel_mask=part`, `rel_pc=pc`.
- On release handshake the barrier goes to IDLE and clears `part`/`arr`.
- `active_mask = ~(OR of arr over all ARMED and RELEASING barriers)`.
- `cmd_ready = ~rel_valid | rel_ready`, so at most one barrier is ever in RELEASING.

## Timing
- Reset values: all barriers IDLE with `part=arr=pc=0`; `rel_valid=0`, `rel_bar=0`, `rel_mask=0`, `rel_pc=0`; `err=0`; `active_mask` all ones. `cmd_ready` reads 1.
- Command accepted at edge N updates barrier state and `active_mask` at edge N.
- A completing command raises `rel_valid` after edge N (latency 1). `err` is high for the single cycle after edge N.
- `rel_*` hold stable while `rel_valid & ~rel_ready`; `rel_valid` drops after the handshake edge unless a new release is loaded at that edge.
- Handshake and an accepted command in the same cycle: the handshake applies first (that barrier goes to IDLE), then the command. A BSSY to the just-released barrier is therefore legal in that cycle.
- The output register reloads on the same edge as the handshake when the command completes another barrier (back-to-back releases, no bubble).
- `rst` asserted mid-operation clears everything immediately, including a pending release; no record is emitted.

## Test plan
- Reset, then BSSY bar0 mask 0x0000_00FF pc 0x0120. BSYNC 0x0F gives `active_mask`=0xFFFF_FFF0 and no release. BSYNC 0xF0 gives `rel_valid`=1 the next cycle with `rel_bar`=0, `rel_mask`=0xFF, `rel_pc`=0x0120; `active_mask` returns to all ones after the handshake.
- With bar1 armed on mask 0x3, BSYNC 0x1, then BBREAK 0x2 releases mask 0x1. BBREAK 0x1 on a fresh 0x1 barrier returns it to IDLE with no release.
- Illegal cases: BSSY on an ARMED barrier, BSYNC on IDLE bar2, and BSYNC 0x100 on a 0xFF barrier each produce a 1-cycle `err`. Partial arrivals of legal bits still apply.
- Hold `rel_ready`=0 with a pending release: `cmd_ready`=0 and `rel_*` stay stable. Raise `rel_ready` in the same cycle as a BSYNC that completes bar3: the bar3 record appears on the next edge.
- Assert `rst` while in RELEASING: on the following cycle `rel_valid`=0, `active_mask`=0xFFFF_FFFF, and a BSSY on the same barrier is accepted without `err`.
